// File: rtl/apb_master_bridge_if.sv
// Bundles the command, response and APB signals of the bridge.
// The master modport is the bridge's view; slave is the environment's view.
interface apb_master_bridge_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  cmd_valid;
   logic                  cmd_ready;
   logic                  cmd_write;
   logic [ADDR_W-1:0]     cmd_addr;
   logic [DATA_W-1:0]     cmd_wdata;
   logic [DATA_W/8-1:0]   cmd_strb;
   logic [2:0]            cmd_prot;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_W-1:0]     rsp_rdata;
   logic                  rsp_slverr;
   logic [ADDR_W-1:0]     PADDR;
   logic [2:0]            PPROT;
   logic                  PSEL;
   logic                  PENABLE;
   logic                  PWRITE;
   logic [DATA_W-1:0]     PWDATA;
   logic [DATA_W/8-1:0]   PSTRB;
   logic                  PREADY;
   logic [DATA_W-1:0]     PRDATA;
   logic                  PSLVERR;
   logic                  busy;
   logic                  wait_timeout;

   modport master (
      input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
      input  rsp_ready, PREADY, PRDATA, PSLVERR,
      output cmd_ready, rsp_valid, rsp_rdata, rsp_slverr,
      output PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
      output busy, wait_timeout
   );

   modport slave (
      output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, cmd_prot,
      output rsp_ready, PREADY, PRDATA, PSLVERR,
      input  cmd_ready, rsp_valid, rsp_rdata, rsp_slverr,
      input  PADDR, PPROT, PSEL, PENABLE, PWRITE, PWDATA, PSTRB,
      input  busy, wait_timeout
   );
endinterface

// File: rtl/apb_master_bridge.sv
// APB5 requester: turns a valid/ready command stream into SETUP/ACCESS
// transfers and returns completions through a 2-entry response FIFO.
//
// state  | meaning
// IDLE   | no transfer, PSEL=0, address/data outputs hold last values
// SETUP  | PSEL=1 PENABLE=0, lasts exactly one cycle
// ACCESS | PSEL=1 PENABLE=1, waits for PREADY, may chain into SETUP
module apb_master_bridge #(
   parameter int ADDR_W     = 32,
   parameter int DATA_W     = 32,
   parameter int WAIT_LIMIT = 16
) (
   input logic                 PCLK,
   input logic                 PRESET,
   apb_master_bridge_if.master bus
);
   localparam int STRB_W = DATA_W / 8;
   localparam int WCNT_W = $clog2(WAIT_LIMIT + 1);

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

   state_t              state, state_nxt;
   logic                push, pop, accept, cmd_ready;
   logic [2:0]          occ_nxt;
   logic [1:0]          cnt;
   logic                wr_ptr, rd_ptr;
   logic [DATA_W-1:0]   fifo_rdata [2];
   logic                fifo_slverr [2];
   logic [WCNT_W-1:0]   wait_cnt;
   logic                timeout_q;
   logic [ADDR_W-1:0]   paddr_q;
   logic [2:0]          pprot_q;
   logic                pwrite_q;
   logic [DATA_W-1:0]   pwdata_q;
   logic [STRB_W-1:0]   pstrb_q;

   always_ff @(posedge PCLK) begin
      if (PRESET) state <= IDLE;
      else        state <= state_nxt;
   end

   // Issue is only allowed when the FIFO is guaranteed room for the new
   // transfer's completion, so PREADY never has to be back-pressured.
   always_comb begin
      push      = (state == ACCESS) && bus.PREADY;
      pop       = (cnt != 2'd0) && bus.rsp_ready;
      occ_nxt   = {1'b0, cnt} + {2'b00, push} - {2'b00, pop};
      cmd_ready = !PRESET && ((state == IDLE) || push) && (occ_nxt <= 3'd1);
      accept    = bus.cmd_valid && cmd_ready;
      state_nxt = state;
      case (state)
         IDLE:    if (accept) state_nxt = SETUP;
         SETUP:   state_nxt = ACCESS;
         ACCESS:  if (bus.PREADY) state_nxt = accept ? SETUP : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         paddr_q  <= '0;
         pprot_q  <= '0;
         pwrite_q <= 1'b0;
         pwdata_q <= '0;
         pstrb_q  <= '0;
      end else if (accept) begin
         paddr_q  <= bus.cmd_addr;
         pprot_q  <= bus.cmd_prot;
         pwrite_q <= bus.cmd_write;
         if (bus.cmd_write) begin
            pwdata_q <= bus.cmd_wdata;
            pstrb_q  <= bus.cmd_strb;
         end else begin
            pstrb_q  <= '0;
         end
      end
   end

   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         cnt            <= 2'd0;
         wr_ptr         <= 1'b0;
         rd_ptr         <= 1'b0;
         fifo_rdata[0]  <= '0;
         fifo_rdata[1]  <= '0;
         fifo_slverr[0] <= 1'b0;
         fifo_slverr[1] <= 1'b0;
      end else begin
         if (push) begin
            fifo_rdata[wr_ptr]  <= pwrite_q ? '0 : bus.PRDATA;
            fifo_slverr[wr_ptr] <= bus.PSLVERR;
            wr_ptr              <= ~wr_ptr;
         end
         if (pop) rd_ptr <= ~rd_ptr;
         cnt <= occ_nxt[1:0];
      end
   end

   // The transfer is never aborted; the counter only records the stall.
   always_ff @(posedge PCLK) begin
      if (PRESET) begin
         wait_cnt  <= '0;
         timeout_q <= 1'b0;
      end else if (state == SETUP) begin
         wait_cnt  <= '0;
      end else if ((state == ACCESS) && !bus.PREADY &&
                   (wait_cnt != WCNT_W'(WAIT_LIMIT))) begin
         wait_cnt <= wait_cnt + 1'b1;
         if (wait_cnt == WCNT_W'(WAIT_LIMIT - 1)) timeout_q <= 1'b1;
      end
   end

   assign bus.cmd_ready    = cmd_ready;
   assign bus.rsp_valid    = (cnt != 2'd0);
   assign bus.rsp_rdata    = fifo_rdata[rd_ptr];
   assign bus.rsp_slverr   = fifo_slverr[rd_ptr];
   assign bus.PADDR        = paddr_q;
   assign bus.PPROT        = pprot_q;
   assign bus.PSEL         = (state != IDLE);
   assign bus.PENABLE      = (state == ACCESS);
   assign bus.PWRITE       = pwrite_q;
   assign bus.PWDATA       = pwdata_q;
   assign bus.PSTRB        = pstrb_q;
   assign bus.busy         = (state != IDLE);
   assign bus.wait_timeout = timeout_q;
endmodule
